// File: rtl/sysmgr_pll_seq_pkg.sv
// Shared definitions for the PLL sequencer: state encoding decoded identically
// by the sequencer and any status/CSR logic, plus sizing helpers.
package sysmgr_pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PRST  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FILT  = 3'd2,
    ST_REL   = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAULT = 3'd5
  } seq_state_t;

  localparam int RETRY_W = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sysmgr_pll_seq_if.sv
// PLL-side and status signals of the sequencer; the sequencer uses the slave
// modport, the surrounding CRG/PLL model uses the master modport.
interface sysmgr_pll_seq_if;
  import sysmgr_pll_seq_pkg::*;

  logic               pll_lock;
  logic               req_restart;
  logic               pll_resetb;
  logic               rst_out;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    output pll_lock, req_restart,
    input  pll_resetb, rst_out, ready, fault, retry_cnt
  );

  modport slave (
    input  pll_lock, req_restart,
    output pll_resetb, rst_out, ready, fault, retry_cnt
  );

endinterface

// File: rtl/sysmgr_pll_seq_sync2.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs; resets to 0.
module sysmgr_pll_seq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sysmgr_pll_seq.sv
// iCE40 PLL reset sequencer: pulses PLL reset, waits for a filtered LOCK with
// timeout/retry, then releases the PLL-domain logic reset after a fixed delay.
module sysmgr_pll_seq
  import sysmgr_pll_seq_pkg::*;
#(
  parameter int RST_PULSE = 16,
  parameter int LOCK_TMO  = 4096,
  parameter int LOCK_FILT = 8,
  parameter int REL_DLY   = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic           clk,
  input  logic           rst,
  sysmgr_pll_seq_if.slave bus
);

  localparam int CNT_MAX = max3(RST_PULSE, LOCK_TMO, REL_DLY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FILT_W  = $clog2(LOCK_FILT + 1);

  localparam logic [CNT_W-1:0]   PRST_LAST  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0]   REL_LAST   = CNT_W'(REL_DLY - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  seq_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [FILT_W-1:0]  filt_cnt;
  logic               lock_s;
  logic               pll_resetb_r;
  logic               rst_out_r;
  logic               ready_r;
  logic               fault_r;
  logic [RETRY_W-1:0] retry_r;

  sysmgr_pll_seq_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_lock),
    .q   (lock_s)
  );

  // cnt is shared: PRST pulse length, lock timeout across WAIT/FILT, REL delay.
  // The filter goes to REL on the edge that sees the LOCK_FILT-th high sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_PRST;
      cnt          <= '0;
      filt_cnt     <= '0;
      pll_resetb_r <= 1'b0;
      rst_out_r    <= 1'b1;
      ready_r      <= 1'b0;
      fault_r      <= 1'b0;
      retry_r      <= '0;
    end else if (bus.req_restart) begin
      state        <= ST_PRST;
      cnt          <= '0;
      filt_cnt     <= '0;
      pll_resetb_r <= 1'b0;
      rst_out_r    <= 1'b1;
      ready_r      <= 1'b0;
      fault_r      <= 1'b0;
      retry_r      <= '0;
    end else begin
      case (state)
        ST_PRST: begin
          if (cnt == PRST_LAST) begin
            state        <= ST_WAIT;
            cnt          <= '0;
            pll_resetb_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT, ST_FILT: begin
          if (cnt == TMO_LAST) begin
            cnt          <= '0;
            filt_cnt     <= '0;
            pll_resetb_r <= 1'b0;
            if (retry_r == RETRY_LAST) begin
              state   <= ST_FAULT;
              fault_r <= 1'b1;
              retry_r <= RETRY_MAX;
            end else begin
              state   <= ST_PRST;
              retry_r <= retry_r + 1'b1;
            end
          end else if (!lock_s) begin
            state    <= ST_WAIT;
            filt_cnt <= '0;
            cnt      <= cnt + 1'b1;
          end else if (filt_cnt == FILT_LAST) begin
            state    <= ST_REL;
            filt_cnt <= '0;
            cnt      <= '0;
          end else begin
            state    <= ST_FILT;
            filt_cnt <= filt_cnt + 1'b1;
            cnt      <= cnt + 1'b1;
          end
        end
        ST_REL, ST_RUN: begin
          // Losing lock after it was qualified restarts cleanly, not as a failed attempt.
          if (!lock_s) begin
            state        <= ST_PRST;
            cnt          <= '0;
            filt_cnt     <= '0;
            pll_resetb_r <= 1'b0;
            rst_out_r    <= 1'b1;
            ready_r      <= 1'b0;
            retry_r      <= '0;
          end else if (state == ST_REL) begin
            if (cnt == REL_LAST) begin
              state     <= ST_RUN;
              cnt       <= '0;
              rst_out_r <= 1'b0;
              ready_r   <= 1'b1;
              retry_r   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_FAULT: begin
          pll_resetb_r <= 1'b0;
          rst_out_r    <= 1'b1;
          fault_r      <= 1'b1;
        end
        default: begin
          state        <= ST_PRST;
          cnt          <= '0;
          filt_cnt     <= '0;
          pll_resetb_r <= 1'b0;
          rst_out_r    <= 1'b1;
          ready_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_resetb = pll_resetb_r;
  assign bus.rst_out    = rst_out_r;
  assign bus.ready      = ready_r;
  assign bus.fault      = fault_r;
  assign bus.retry_cnt  = retry_r;

endmodule

// File: tb/tb_sysmgr_pll_seq.sv
// Bench for sysmgr_pll_seq: vector table drives lock/restart per cycle and queues
// the outputs expected one clock later; async-reset corner is hand-sequenced.
module tb_sysmgr_pll_seq;
  import sysmgr_pll_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sysmgr_pll_seq_if bus ();

  sysmgr_pll_seq #(
    .RST_PULSE (4),
    .LOCK_TMO  (32),
    .LOCK_FILT (3),
    .REL_DLY   (2),
    .MAX_RETRY (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected bundle: {pll_resetb, rst_out, ready, fault, retry_cnt[2:0]}
  typedef struct {
    string      name;
    int         n;
    logic       lock;
    logic       restart;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  localparam logic [6:0] E_RESET = 7'b0100000;
  localparam logic [6:0] E_RUN   = 7'b1010000;
  localparam logic [6:0] E_FAULT = 7'b0101011;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [6:0] e_prst(input int r);
    return {1'b0, 1'b1, 1'b0, 1'b0, 3'(r)};
  endfunction

  function automatic logic [6:0] e_wait(input int r);
    return {1'b1, 1'b1, 1'b0, 1'b0, 3'(r)};
  endfunction

  task automatic add_vec(input string name, input int n, input logic lock,
                         input logic restart, input logic [6:0] exp);
    vec_t v;
    v.name    = name;
    v.n       = n;
    v.lock    = lock;
    v.restart = restart;
    v.exp     = exp;
    vecs.push_back(v);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [6:0] act;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
    end else begin
      e   = exp_q.pop_front();
      act = {bus.pll_resetb, bus.rst_out, bus.ready, bus.fault, bus.retry_cnt};
      if (act !== e.exp) begin
        n_bad++;
        $display("[TB] FAIL %s @%0t: got pb=%b rst_out=%b ready=%b fault=%b retry=%0d, required pb=%b rst_out=%b ready=%b fault=%b retry=%0d",
                 e.name, $time, act[6], act[5], act[4], act[3], act[2:0],
                 e.exp[6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
      end
    end
  endtask

  task automatic expect_now(input string name, input logic [6:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    checkOutput();
  endtask

  // Called at a falling edge: drive, queue the post-edge expectation, compare one cycle on.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    for (int i = 0; i < v.n; i++) begin
      bus.pll_lock    = v.lock;
      bus.req_restart = v.restart;
      e.name = v.name;
      e.exp  = v.exp;
      exp_q.push_back(e);
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.pll_lock    = 1'b0;
    bus.req_restart = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    expect_now("reset_state", E_RESET);
    rst = 1'b0;

    // Normal bring-up, lock raised 5 cycles after pll_resetb rises
    add_vec("t1_prst",  3, 1'b0, 1'b0, e_prst(0));
    add_vec("t1_wait",  6, 1'b0, 1'b0, e_wait(0));
    add_vec("t1_lock",  6, 1'b1, 1'b0, e_wait(0));
    add_vec("t1_run",   5, 1'b1, 1'b0, E_RUN);
    // Two-cycle lock glitch must not qualify
    add_vec("t2_restart", 1, 1'b0, 1'b1, e_prst(0));
    add_vec("t2_prst",    3, 1'b0, 1'b0, e_prst(0));
    add_vec("t2_wait",    3, 1'b0, 1'b0, e_wait(0));
    add_vec("t2_glitch",  2, 1'b1, 1'b0, e_wait(0));
    add_vec("t2_low",     3, 1'b0, 1'b0, e_wait(0));
    add_vec("t2_lock",    6, 1'b1, 1'b0, e_wait(0));
    add_vec("t2_run",     4, 1'b1, 1'b0, E_RUN);
    // One-cycle lock drop in RUN
    add_vec("t4_drop",    1, 1'b0, 1'b0, E_RUN);
    add_vec("t4_back",    1, 1'b1, 1'b0, E_RUN);
    add_vec("t4_prst",    4, 1'b1, 1'b0, e_prst(0));
    add_vec("t4_relock",  5, 1'b1, 1'b0, e_wait(0));
    add_vec("t4_run",     3, 1'b1, 1'b0, E_RUN);
    // Lock never arrives: three timeouts then FAULT
    add_vec("t3_restart", 1, 1'b0, 1'b1, e_prst(0));
    add_vec("t3_prst0",   3, 1'b0, 1'b0, e_prst(0));
    add_vec("t3_wait0",  32, 1'b0, 1'b0, e_wait(0));
    add_vec("t3_prst1",   4, 1'b0, 1'b0, e_prst(1));
    add_vec("t3_wait1",  32, 1'b0, 1'b0, e_wait(1));
    add_vec("t3_prst2",   4, 1'b0, 1'b0, e_prst(2));
    add_vec("t3_wait2",  32, 1'b0, 1'b0, e_wait(2));
    add_vec("t3_fault",   6, 1'b0, 1'b0, E_FAULT);
    // Restart out of FAULT with lock already high
    add_vec("t5_lockup",  4, 1'b1, 1'b0, E_FAULT);
    add_vec("t5_restart", 1, 1'b1, 1'b1, e_prst(0));
    add_vec("t5_prst",    3, 1'b1, 1'b0, e_prst(0));
    add_vec("t5_filt",    5, 1'b1, 1'b0, e_wait(0));
    add_vec("t5_run",     3, 1'b1, 1'b0, E_RUN);
    // Restart on the exact timeout edge must win (retry stays 0)
    add_vec("t5b_restart",     1, 1'b0, 1'b1, e_prst(0));
    add_vec("t5b_prst",        3, 1'b0, 1'b0, e_prst(0));
    add_vec("t5b_wait",       32, 1'b0, 1'b0, e_wait(0));
    add_vec("t5b_tmo_restart", 1, 1'b0, 1'b1, e_prst(0));
    add_vec("t5b_prst2",       3, 1'b1, 1'b0, e_prst(0));
    add_vec("t5b_filt",        5, 1'b1, 1'b0, e_wait(0));
    add_vec("t5b_run",         3, 1'b1, 1'b0, E_RUN);
    // Walk back into REL for the async-reset corner
    add_vec("t6_drop",    1, 1'b0, 1'b0, E_RUN);
    add_vec("t6_back",    1, 1'b1, 1'b0, E_RUN);
    add_vec("t6_prst",    4, 1'b1, 1'b0, e_prst(0));
    add_vec("t6_rel",     4, 1'b1, 1'b0, e_wait(0));
    run_vecs();

    // Now in REL: async reset must act without a clock edge
    #2 rst = 1'b1;
    #1 expect_now("t6_async_reset", E_RESET);
    @(negedge clk);
    expect_now("t6_reset_hold", E_RESET);
    rst = 1'b0;
    add_vec("t6_post_prst", 3, 1'b1, 1'b0, e_prst(0));
    add_vec("t6_post_wait", 5, 1'b1, 1'b0, e_wait(0));
    add_vec("t6_post_run",  3, 1'b1, 1'b0, E_RUN);
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
